// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register file write port between A and B
// Optional WBARB_STATS_EN adds a saturating conflict_count output.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [IDX_W-1:0]  a_index,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [IDX_W-1:0]  b_index,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic              write_en,
  output logic [IDX_W-1:0]  write_index,
  output logic [DATA_W-1:0] write_data,
  output logic              pend_valid,
  output logic [IDX_W-1:0]  pend_index,
  input  logic [IDX_W-1:0]  rd1_index,
  input  logic [IDX_W-1:0]  rd2_index,
  output logic              rd1_fwd,
  output logic              rd2_fwd
`ifdef WBARB_STATS_EN
  ,
  output logic [15:0]       conflict_count
`endif
);

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

  pri_t pri, pri_next;

  always_ff @(posedge clk) begin
    if (rst) pri <= PRI_A;
    else     pri <= pri_next;
  end

  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    pend_valid = 1'b0;
    pend_index = '0;
    pri_next   = pri;
    if (!rst) begin
      if (a_req && b_req) begin
        pend_valid = 1'b1;
        if (pri == PRI_A) begin
          a_gnt      = 1'b1;
          pend_index = b_index;
        end else begin
          b_gnt      = 1'b1;
          pend_index = a_index;
        end
      end else if (a_req) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
      // Favour whoever lost (or would lose) next time.
      if (a_gnt)      pri_next = PRI_B;
      else if (b_gnt) pri_next = PRI_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en    <= 1'b0;
      write_index <= '0;
      write_data  <= '0;
    end else begin
      write_en <= a_gnt | b_gnt;
      if (a_gnt) begin
        write_index <= a_index;
        write_data  <= a_data;
      end else if (b_gnt) begin
        write_index <= b_index;
        write_data  <= b_data;
      end
    end
  end

  assign rd1_fwd = write_en && (write_index == rd1_index);
  assign rd2_fwd = write_en && (write_index == rd2_index);

`ifdef WBARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      conflict_count <= '0;
    else if (a_req && b_req && conflict_count != 16'hFFFF)
      conflict_count <= conflict_count + 16'd1;
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: A (ALU result) and B (load data).
- Arbitration is round-robin with a same-cycle grant.
- The winning write is registered and driven to the register file's write_en/write_index/write_data one cycle later.
- Also exports the pending loser and a forwarding match against the in-flight write, so decode can stall or bypass.

Parameters:
- DATA_W, 16, width of write data.
- IDX_W, 5, width of register index (32 registers).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- a_req  in  1  requester A has a write pending
- a_index  in  IDX_W  A destination register
- a_data  in  DATA_W  A write data
- a_gnt  out  1  A granted this cycle (combinational)
- b_req  in  1  requester B has a write pending
- b_index  in  IDX_W  B destination register
- b_data  in  DATA_W  B write data
- b_gnt  out  1  B granted this cycle (combinational)
- write_en  out  1  to register file write_en (registered)
- write_index  out  IDX_W  to register file write_index (registered)
- write_data  out  DATA_W  to register file write_data (registered)
- pend_valid  out  1  a requester was refused this cycle (combinational)
- pend_index  out  IDX_W  index of the refused request; 0 when pend_valid=0
- rd1_index  in  IDX_W  decode read port 1 index
- rd2_index  in  IDX_W  decode read port 2 index
- rd1_fwd  out  1  write_en && write_index==rd1_index
- rd2_fwd  out  1  write_en && write_index==rd2_index

Behaviour:
- State: pri bit (0 = A favoured, 1 = B favoured), output regs write_en/write_index/write_data.
- Reset (rst=1 at edge): pri=0, write_en=0, write_index=0, write_data=0. While rst=1, a_gnt=b_gnt=0 and pend_valid=0.
- Grant:
  - Only a_req: a_gnt=1.
  - Only b_req: b_gnt=1.
  - Both: grant the favoured requester; the other gets pend_valid=1, pend_index=its index.
  - Neither: no grant.
  - a_gnt and b_gnt are never both 1.
- pri update at edge:
  - After a grant, pri points to the non-granted requester (A granted -> pri=1; B granted -> pri=0).
  - No grant -> pri holds.
- Requester contract: req, index and data are held stable until gnt is seen. A requester may drop req without being granted; it is then simply not considered.
- Latency: grant in cycle N -> write_en=1 with the granted index/data in cycle N+1. The register file commits at the end of cycle N+1. No grant in N -> write_en=0 in N+1; write_index/write_data hold their previous values.
- Throughput: one write per cycle. A continuously contending pair alternates A,B,A,B; the maximum wait is 1 cycle.
- Same destination index on both requesters: no special handling. Writes are issued in grant order, so the later grant wins in the register file.
- Forwarding: rd*_fwd compare against the registered write stage only. The consumer muxes write_data when the flag is set. Index 0 is compared like any other index.
- Reset mid-operation: an in-flight write (write_en=1) is dropped at the reset edge. Requests still asserted after rst falls are re-arbitrated from pri=0.

Optional Feature:
- Macro: WBARB_STATS_EN.
- Defined:
  - Adds output conflict_count (16 bits).
  - Increments every cycle with a_req&&b_req&&!rst, saturating at 16'hFFFF.
  - Cleared to 0 by rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle with no requests -> write_en=0, write_index=0, write_data=0, a_gnt=b_gnt=0, pri=0 for all cycles.
- a_req only, index 3, data 16'h1234 at cycle 5 -> a_gnt=1 in cycle 5; write_en=1, write_index=3, write_data=16'h1234 in cycle 6; write_en=0 in cycle 7.
- Both requesting, A(idx 4, 16'hAAAA) and B(idx 9, 16'hBBBB), held until granted -> from reset:
  - cycle 0: A granted; pend_valid=1, pend_index=9.
  - cycle 1: B granted.
  - Register file sees idx 4 then idx 9 on consecutive cycles.
- Continuous contention for 6 cycles with fresh data each grant -> grants alternate A,B,A,B,A,B. With WBARB_STATS_EN, conflict_count=6.
- Write of idx 7 in flight, rd1_index=7, rd2_index=8 -> rd1_fwd=1, rd2_fwd=0 in the write_en cycle; both 0 the next cycle.
- Assert rst in the cycle after granting A(idx 2) -> write_en=0 after the reset edge; with b_req held, B is granted after rst falls only if A is not requesting (pri back to 0).
